// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared FSM state type and byte-parity helper for the instruction memory
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } imem_state_e;

  localparam int MAX_WORD_BYTES = 8;

  // Even parity per byte: bit i makes byte i plus its parity bit have an even count of ones.
  function automatic logic [MAX_WORD_BYTES-1:0] byte_parity(input logic [MAX_WORD_BYTES*8-1:0] data);
    logic [MAX_WORD_BYTES-1:0] p;
    for (int i = 0; i < MAX_WORD_BYTES; i++) begin
      p[i] = ^data[8*i +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/cpu_imem_loader.sv
// rtl/cpu_imem_loader.sv - load sequencer: IDLE/LOAD/RUN FSM, write pointer, ld_ready and ld_done
import cpu_pkg::*;

module cpu_imem_loader #(
  parameter int ADDR_W     = 16,
  parameter int WORD_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W-1:0] ld_len,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output imem_state_e       state
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(WORD_BYTES - 1);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(WORD_BYTES);

  imem_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE, RUN: begin
          if (ld_start) begin
            ptr_q  <= ld_base & ~ALIGN_MASK;
            cnt_q  <= ld_len;
            done_q <= (ld_len == '0);
          end
        end
        LOAD: begin
          if (ld_valid) begin
            ptr_q <= ptr_q + STEP;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == ADDR_W'(1)) done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ld_start is only honoured outside LOAD, so a load in progress cannot be restarted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RUN: begin
        if (ld_start) state_d = (ld_len != '0) ? LOAD : RUN;
      end
      LOAD: begin
        if (ld_valid && cnt_q == ADDR_W'(1)) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ld_ready = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = ptr_q;
    ld_done  = done_q;
    state    = state_q;
    if (state_q == LOAD) begin
      ld_ready = 1'b1;
      wr_en    = ld_valid;
    end
  end

endmodule

// File: rtl/cpu_imem_param.sv
// rtl/cpu_imem_param.sv - loadable instruction memory with pipelined fetch; CPU_IMEM_PARITY_EN adds byte parity
import cpu_pkg::*;

module cpu_imem_param #(
  parameter int ADDR_W     = 16,
  parameter int WORD_BYTES = 4,
  parameter int RD_LAT     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld_start,
  input  logic [ADDR_W-1:0]       ld_base,
  input  logic [ADDR_W-1:0]       ld_len,
  input  logic                    ld_valid,
  input  logic [WORD_BYTES*8-1:0] ld_data,
  output logic                    ld_ready,
  output logic                    ld_done,
  input  logic                    f_req,
  input  logic [ADDR_W-1:0]       f_addr,
  output logic                    f_ready,
  output logic                    f_rvalid,
  output logic [WORD_BYTES*8-1:0] f_rdata,
  output logic                    f_misalign,
  output logic                    rd_perr
);

  localparam int DATA_W = WORD_BYTES * 8;
  localparam int OFF_W  = $clog2(WORD_BYTES);
  localparam int IDX_W  = ADDR_W - OFF_W;
  localparam int DEPTH  = 1 << IDX_W;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(WORD_BYTES - 1);

  // Word-organised storage: aligned words never straddle the top of memory,
  // so address wrap falls out of the index arithmetic.
  logic [DATA_W-1:0] mem [DEPTH];

  imem_state_e       state;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  f_idx;
  logic              f_mis;
  logic              f_accept;
  logic [DATA_W-1:0] rd_word;
  logic              perr_c;

  cpu_imem_loader #(
    .ADDR_W     (ADDR_W),
    .WORD_BYTES (WORD_BYTES)
  ) u_loader (
    .clk      (clk),
    .rst      (rst),
    .ld_start (ld_start),
    .ld_base  (ld_base),
    .ld_len   (ld_len),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_done  (ld_done),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .state    (state)
  );

  assign wr_idx   = IDX_W'(wr_addr >> OFF_W);
  assign f_idx    = IDX_W'(f_addr >> OFF_W);
  assign f_mis    = (f_addr & OFF_MASK) != '0;
  assign f_ready  = (state == RUN);
  assign f_accept = f_req & f_ready;
  assign rd_word  = mem[f_idx];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= ld_data;
  end

`ifdef CPU_IMEM_PARITY_EN
  logic [WORD_BYTES-1:0]     par_mem [DEPTH];
  logic [MAX_WORD_BYTES-1:0] par_wr;
  logic [MAX_WORD_BYTES-1:0] par_rd;

  assign par_wr = byte_parity(64'(ld_data));
  assign par_rd = byte_parity(64'(rd_word));
  assign perr_c = (par_rd != MAX_WORD_BYTES'(par_mem[f_idx]));

  always_ff @(posedge clk) begin
    if (wr_en) par_mem[wr_idx] <= par_wr[WORD_BYTES-1:0];
  end
`else
  assign perr_c = 1'b0;
`endif

  logic              v1, m1, p1;
  logic [DATA_W-1:0] d1;

  // Data registers load only on a response so f_rdata holds between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      m1 <= 1'b0;
      p1 <= 1'b0;
      d1 <= '0;
    end else begin
      v1 <= f_accept;
      m1 <= f_accept & f_mis;
      p1 <= f_accept & ~f_mis & perr_c;
      if (f_accept) d1 <= f_mis ? '0 : rd_word;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              v2, m2, p2;
      logic [DATA_W-1:0] d2;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v2 <= 1'b0;
          m2 <= 1'b0;
          p2 <= 1'b0;
          d2 <= '0;
        end else begin
          v2 <= v1;
          m2 <= m1;
          p2 <= p1;
          if (v1) d2 <= d1;
        end
      end

      assign f_rvalid   = v2;
      assign f_misalign = m2;
      assign rd_perr    = p2;
      assign f_rdata    = d2;
    end else begin : g_lat1
      assign f_rvalid   = v1;
      assign f_misalign = m1;
      assign rd_perr    = p1;
      assign f_rdata    = d1;
    end
  endgenerate

endmodule

// File: tb/tb_cpu_imem_param.sv
// tb/tb_cpu_imem_param.sv - scoreboard bench for cpu_imem_param at RD_LAT 1 and 2
module tb_cpu_imem_param;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld_start = 1'b0;
  logic [AW-1:0] ld_base = '0;
  logic [AW-1:0] ld_len = '0;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          f_req = 1'b0;
  logic [AW-1:0] f_addr = '0;

  logic          ld_ready_a, ld_done_a, f_ready_a, f_rvalid_a, f_misalign_a, rd_perr_a;
  logic [DW-1:0] f_rdata_a;
  logic          ld_ready_b, ld_done_b, f_ready_b, f_rvalid_b, f_misalign_b, rd_perr_b;
  logic [DW-1:0] f_rdata_b;

  cpu_imem_param #(.ADDR_W(AW), .WORD_BYTES(4), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready_a), .ld_done(ld_done_a),
    .f_req(f_req), .f_addr(f_addr), .f_ready(f_ready_a), .f_rvalid(f_rvalid_a),
    .f_rdata(f_rdata_a), .f_misalign(f_misalign_a), .rd_perr(rd_perr_a)
  );

  cpu_imem_param #(.ADDR_W(AW), .WORD_BYTES(4), .RD_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready_b), .ld_done(ld_done_b),
    .f_req(f_req), .f_addr(f_addr), .f_ready(f_ready_b), .f_rvalid(f_rvalid_b),
    .f_rdata(f_rdata_b), .f_misalign(f_misalign_b), .rd_perr(rd_perr_b)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          mis;
    logic          perr;
    int            due;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb, en;
  logic [DW-1:0] last_a = '0;
  logic [DW-1:0] last_b = '0;
  int            accepts = 0;

  logic [7:0]    mm [0:65535];
  logic [DW-1:0] ld_words [0:7];
  logic [AW-1:0] f_list [0:7];
  logic          corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;

  function automatic logic [DW-1:0] model_word(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = mm[16'(a + 16'(b))];
    return w;
  endfunction

  // Scoreboard: expectations pushed on acceptance, popped when each DUT's latency elapses.
  always @(negedge clk) begin
    if (rst) begin
      q_a.delete();
      q_b.delete();
      last_a = '0;
      last_b = '0;
    end else begin
      tests_run++;
      if (q_a.size() > 0 && q_a[0].due == cyc) begin
        ea = q_a.pop_front();
        if (f_rvalid_a !== 1'b1 || f_rdata_a !== ea.data || f_misalign_a !== ea.mis || rd_perr_a !== ea.perr) begin
          tests_failed++;
          $display("FAIL resp_lat1 addr=%h got v=%b d=%h m=%b p=%b exp d=%h m=%b p=%b",
                   ea.addr, f_rvalid_a, f_rdata_a, f_misalign_a, rd_perr_a, ea.data, ea.mis, ea.perr);
        end
        last_a = ea.data;
      end else if (f_rvalid_a !== 1'b0 || f_rdata_a !== last_a) begin
        tests_failed++;
        $display("FAIL idle_lat1 got v=%b d=%h exp v=0 d=%h", f_rvalid_a, f_rdata_a, last_a);
      end
      tests_run++;
      if (q_b.size() > 0 && q_b[0].due == cyc) begin
        eb = q_b.pop_front();
        if (f_rvalid_b !== 1'b1 || f_rdata_b !== eb.data || f_misalign_b !== eb.mis || rd_perr_b !== eb.perr) begin
          tests_failed++;
          $display("FAIL resp_lat2 addr=%h got v=%b d=%h m=%b p=%b exp d=%h m=%b p=%b",
                   eb.addr, f_rvalid_b, f_rdata_b, f_misalign_b, rd_perr_b, eb.data, eb.mis, eb.perr);
        end
        last_b = eb.data;
      end else if (f_rvalid_b !== 1'b0 || f_rdata_b !== last_b) begin
        tests_failed++;
        $display("FAIL idle_lat2 got v=%b d=%h exp v=0 d=%h", f_rvalid_b, f_rdata_b, last_b);
      end
      if (f_req && f_ready_a) begin
        accepts++;
        en.addr = f_addr;
        en.mis  = (f_addr[1:0] != 2'b00);
        en.data = en.mis ? '0 : model_word(f_addr);
        en.perr = corrupt_en && !en.mis && (f_addr == corrupt_addr);
        en.due  = cyc + 1;
        q_a.push_back(en);
        en.due  = cyc + 2;
        q_b.push_back(en);
      end
    end
  end

  task automatic do_load(input logic [AW-1:0] base, input logic [AW-1:0] len, input int abort_after,
                         output int beats, output int done_cnt, output int done_delay, output int stall_bad);
    logic [AW-1:0] ptr;
    int last_iter;
    beats = 0; done_cnt = 0; done_delay = -1; stall_bad = 0; last_iter = 0;
    ptr = base & 16'hFFFC;
    @(posedge clk); #1;
    ld_start = 1'b1; ld_base = base; ld_len = len; ld_valid = (len != 0); ld_data = ld_words[0];
    for (int iter = 0; iter < 40; iter++) begin
      @(negedge clk);
      if (ld_done_a) begin
        done_cnt++;
        if (done_delay < 0) done_delay = iter - last_iter;
      end
      if (ld_ready_a && f_ready_a) stall_bad = 1;
      if (ld_ready_a && ld_valid) begin
        for (int b = 0; b < 4; b++) mm[16'(ptr + 16'(b))] = ld_data[8*b +: 8];
        ptr = ptr + 16'd4;
        beats++;
        last_iter = iter;
        if (beats == abort_after) begin
          @(posedge clk); #1;
          rst = 1'b1; ld_valid = 1'b0; ld_start = 1'b0;
          return;
        end
      end
      if (done_cnt > 0 && iter > last_iter + 3) break;
      @(posedge clk); #1;
      ld_start = 1'b0;
      if (beats >= int'(len)) ld_valid = 1'b0;
      else ld_data = ld_words[beats];
    end
    ld_start = 1'b0;
    ld_valid = 1'b0;
  endtask

  task automatic do_fetch(input int n, output int acc, output bit drained);
    int a0;
    a0 = accepts;
    drained = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      f_req = 1'b1;
      f_addr = f_list[i];
      @(posedge clk); #1;
    end
    f_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (q_a.size() == 0 && q_b.size() == 0) begin
        drained = 1'b1;
        break;
      end
    end
    acc = accepts - a0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({ld_ready_a, ld_done_a, f_ready_a, f_rvalid_a, f_rdata_a, f_misalign_a, rd_perr_a} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs_lat1 got rdy=%b done=%b frdy=%b v=%b d=%h m=%b p=%b exp all 0",
               ld_ready_a, ld_done_a, f_ready_a, f_rvalid_a, f_rdata_a, f_misalign_a, rd_perr_a);
    end
    tests_run++;
    if ({ld_ready_b, ld_done_b, f_ready_b, f_rvalid_b, f_rdata_b, f_misalign_b, rd_perr_b} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs_lat2 got rdy=%b done=%b frdy=%b v=%b d=%h m=%b p=%b exp all 0",
               ld_ready_b, ld_done_b, f_ready_b, f_rvalid_b, f_rdata_b, f_misalign_b, rd_perr_b);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (f_ready_a !== 1'b0 || ld_ready_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_stall got f_ready=%b ld_ready=%b exp 0 0", f_ready_a, ld_ready_a);
    end
  endtask

  task automatic test_load;
    int beats, dc, dd, sb;
    ld_words[0] = 32'h11223344; ld_words[1] = 32'h22334455;
    ld_words[2] = 32'h33445566; ld_words[3] = 32'h44556677;
    do_load(16'h0000, 16'd4, 0, beats, dc, dd, sb);
    tests_run++;
    if (beats != 4 || dc != 1 || dd != 1 || sb != 0) begin
      tests_failed++;
      $display("FAIL load4 got beats=%0d done_pulses=%0d done_delay=%0d stall_bad=%0d exp 4 1 1 0", beats, dc, dd, sb);
    end
    tests_run++;
    if (f_ready_a !== 1'b1 || ld_ready_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL load4_run got f_ready=%b ld_ready=%b exp 1 0", f_ready_a, ld_ready_a);
    end
  endtask

  task automatic test_back_to_back;
    int acc; bit dr;
    f_list[0] = 16'h0000; f_list[1] = 16'h0004; f_list[2] = 16'h0008; f_list[3] = 16'h000C;
    do_fetch(4, acc, dr);
    tests_run++;
    if (acc != 4 || !dr) begin
      tests_failed++;
      $display("FAIL b2b_fetch got accepted=%0d drained=%0d exp 4 1", acc, dr);
    end
  endtask

  task automatic test_misalign;
    int acc; bit dr;
    f_list[0] = 16'h000C; f_list[1] = 16'h0002; f_list[2] = 16'h0004; f_list[3] = 16'h0007;
    do_fetch(4, acc, dr);
    tests_run++;
    if (acc != 4 || !dr) begin
      tests_failed++;
      $display("FAIL misalign_fetch got accepted=%0d drained=%0d exp 4 1", acc, dr);
    end
  endtask

  task automatic test_wrap;
    int beats, dc, dd, sb, acc; bit dr;
    ld_words[0] = 32'hCAFE0001; ld_words[1] = 32'hCAFE0002;
    do_load(16'hFFFC, 16'd2, 0, beats, dc, dd, sb);
    tests_run++;
    if (beats != 2 || dc != 1 || dd != 1) begin
      tests_failed++;
      $display("FAIL wrap_load got beats=%0d done_pulses=%0d done_delay=%0d exp 2 1 1", beats, dc, dd);
    end
    ld_words[0] = 32'h5A5A0010;
    do_load(16'h0013, 16'd1, 0, beats, dc, dd, sb);
    tests_run++;
    if (beats != 1 || dc != 1) begin
      tests_failed++;
      $display("FAIL unaligned_base_load got beats=%0d done_pulses=%0d exp 1 1", beats, dc);
    end
    f_list[0] = 16'hFFFC; f_list[1] = 16'h0000; f_list[2] = 16'h0010; f_list[3] = 16'h0004;
    do_fetch(4, acc, dr);
    tests_run++;
    if (acc != 4 || !dr) begin
      tests_failed++;
      $display("FAIL wrap_fetch got accepted=%0d drained=%0d exp 4 1", acc, dr);
    end
  endtask

  task automatic test_reset_midload;
    int beats, dc, dd, sb, acc; bit dr; bit done_seen;
    ld_words[0] = 32'hA1A1A1A1; ld_words[1] = 32'hB2B2B2B2;
    ld_words[2] = 32'hC3C3C3C3; ld_words[3] = 32'hD4D4D4D4;
    do_load(16'h0000, 16'd4, 2, beats, dc, dd, sb);
    @(negedge clk);
    tests_run++;
    if ({ld_ready_a, ld_done_a, f_ready_a, f_rvalid_a, f_rdata_a, f_misalign_a, rd_perr_a,
         ld_ready_b, ld_done_b, f_ready_b, f_rvalid_b, f_rdata_b, f_misalign_b, rd_perr_b} !== '0) begin
      tests_failed++;
      $display("FAIL midload_reset_outputs got rdy=%b done=%b frdy=%b v=%b d=%h exp all 0",
               ld_ready_a, ld_done_a, f_ready_a, f_rvalid_a, f_rdata_a);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    done_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ld_done_a || ld_done_b || ld_ready_a) done_seen = 1'b1;
    end
    tests_run++;
    if (beats != 2 || done_seen) begin
      tests_failed++;
      $display("FAIL midload_no_done got beats=%0d done_or_ready_seen=%0d exp 2 0", beats, done_seen);
    end
    do_load(16'h0000, 16'd0, 0, beats, dc, dd, sb);
    tests_run++;
    if (beats != 0 || dc != 1 || dd != 1 || f_ready_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_len_load got beats=%0d done_pulses=%0d done_delay=%0d f_ready=%b exp 0 1 1 1",
               beats, dc, dd, f_ready_a);
    end
    f_list[0] = 16'h0004; f_list[1] = 16'h0000; f_list[2] = 16'h0008;
    do_fetch(3, acc, dr);
    tests_run++;
    if (acc != 3 || !dr) begin
      tests_failed++;
      $display("FAIL post_reset_fetch got accepted=%0d drained=%0d exp 3 1", acc, dr);
    end
  endtask

  task automatic test_reset_inflight;
    int beats, dc, dd, sb; bit seen;
    @(posedge clk); #1;
    f_req = 1'b1; f_addr = 16'h0004;
    @(posedge clk); #1;
    f_req = 1'b0; rst = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (f_rvalid_a !== 1'b0 || f_rvalid_b !== 1'b0) seen = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (f_rvalid_a !== 1'b0 || f_rvalid_b !== 1'b0) seen = 1'b1;
    end
    tests_run++;
    if (seen) begin
      tests_failed++;
      $display("FAIL inflight_discard got rvalid_seen=1 exp 0");
    end
    do_load(16'h0000, 16'd0, 0, beats, dc, dd, sb);
  endtask

`ifdef CPU_IMEM_PARITY_EN
  task automatic test_parity;
    int acc; bit dr;
    corrupt_addr = 16'h0004;
    dut.par_mem[1][0] = ~dut.par_mem[1][0];
    dut_b.par_mem[1][0] = ~dut_b.par_mem[1][0];
    corrupt_en = 1'b1;
    f_list[0] = 16'h0000; f_list[1] = 16'h0004; f_list[2] = 16'h0008;
    do_fetch(3, acc, dr);
    tests_run++;
    if (acc != 3 || !dr) begin
      tests_failed++;
      $display("FAIL parity_fetch got accepted=%0d drained=%0d exp 3 1", acc, dr);
    end
    corrupt_en = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_misalign();
    test_wrap();
    test_reset_midload();
    test_reset_inflight();
`ifdef CPU_IMEM_PARITY_EN
    test_parity();
`endif
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
